// File: rtl/ring_counter.sv
// ring_counter -- one-hot ring counter used as a sequencer / phase generator.
//
// A single 1 is loaded by `init` and walks from out[0] toward out[WIDTH-1]
// on every enabled rising edge, then wraps back to out[0]. All outputs come
// straight from flops.
//
// Optional build macro: RING_ONEHOT_CHECK_EN
//   When defined, adds the `err` output and a one-hot checker. Once the
//   counter is running (at least one init since reset), a state that is not
//   exactly one-hot raises `err` on the next edge and reloads SEED.
//
// Ports:
//   clock  in   rising-edge system clock
//   rst_n  in   asynchronous active-low reset (clears out, tc, err)
//   init   in   synchronous load of SEED, highest priority
//   en     in   shift enable; hold when low
//   out    out  [0:WIDTH-1] ring state, index 0 is the first stage
//   tc     out  terminal count, equal to out[WIDTH-1]
//   err    out  (RING_ONEHOT_CHECK_EN only) registered one-hot violation flag
module ring_counter #(
  parameter int                 WIDTH = 8,
  parameter logic [0:WIDTH-1]   SEED  = {1'b1, {(WIDTH-1){1'b0}}}
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             init,
  input  logic             en,
  output logic [0:WIDTH-1] out,
`ifdef RING_ONEHOT_CHECK_EN
  output logic             err,
`endif
  output logic             tc
);

  logic [0:WIDTH-1] out_q;
  logic [0:WIDTH-1] out_d;
  logic [0:WIDTH-1] rot_s;

  // Rotation toward the last stage: out[i+1] <= out[i], out[0] <= out[WIDTH-1].
  assign rot_s = {out_q[WIDTH-1], out_q[0:WIDTH-2]};

`ifdef RING_ONEHOT_CHECK_EN
  logic err_q;
  logic err_d;
  logic running_q;
  logic running_d;

  // True when exactly one bit of the vector is set.
  function automatic logic is_onehot(input logic [0:WIDTH-1] v);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) begin
        cnt = cnt + 1;
      end else begin
        cnt = cnt;
      end
    end
    return (cnt == 1);
  endfunction

  // Next state: init reloads and arms the checker; a bad state while running
  // is replaced by SEED instead of being rotated.
  always_comb begin
    out_d     = out_q;
    err_d     = 1'b0;
    running_d = running_q;
    if (init) begin
      out_d     = SEED;
      err_d     = 1'b0;
      running_d = 1'b1;
    end else if (running_q && !is_onehot(out_q)) begin
      out_d     = SEED;
      err_d     = 1'b1;
      running_d = 1'b1;
    end else if (en) begin
      out_d     = rot_s;
      err_d     = 1'b0;
      running_d = running_q;
    end else begin
      out_d     = out_q;
      err_d     = 1'b0;
      running_d = running_q;
    end
  end

  // Checker state registers.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      err_q     <= 1'b0;
      running_q <= 1'b0;
    end else begin
      err_q     <= err_d;
      running_q <= running_d;
    end
  end

  assign err = err_q;
`else
  // Next state: init > en (rotate) > hold. Any pattern, including all-zeros,
  // simply rotates.
  always_comb begin
    out_d = out_q;
    if (init) begin
      out_d = SEED;
    end else if (en) begin
      out_d = rot_s;
    end else begin
      out_d = out_q;
    end
  end
`endif

  // Ring state register; cleared to the all-zeros idle state on reset.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= {WIDTH{1'b0}};
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;
  // Terminal count is the last stage flop itself, so it tracks out with no lag.
  assign tc  = out_q[WIDTH-1];

endmodule

// File: tb/tb_ring_counter.sv
// Scoreboard bench for ring_counter (WIDTH=8). The driver pushes the
// hand-computed expected state for each edge; an independent monitor pops
// and compares one entry after every rising edge.
module tb_ring_counter;

  logic       clock;
  logic       rst_n;
  logic       init;
  logic       en;
  logic [0:7] out;
  logic       tc;
`ifdef RING_ONEHOT_CHECK_EN
  logic       err;
`endif

  int checks;
  int failures;

  typedef struct {
    logic [0:7] o;
    logic       t;
    logic       e;
    int         id;
  } exp_t;

  exp_t sb_q[$];
  int   vec_id;

  ring_counter #(.WIDTH(8)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .init  (init),
    .en    (en),
    .out   (out),
`ifdef RING_ONEHOT_CHECK_EN
    .err   (err),
`endif
    .tc    (tc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Walking-one table in [0:7] order: entry k is the state k edges after SEED.
  logic [0:7] walk [0:7];
  initial begin
    walk[0] = 8'b1000_0000;
    walk[1] = 8'b0100_0000;
    walk[2] = 8'b0010_0000;
    walk[3] = 8'b0001_0000;
    walk[4] = 8'b0000_1000;
    walk[5] = 8'b0000_0100;
    walk[6] = 8'b0000_0010;
    walk[7] = 8'b0000_0001;
  end

  // Drive inputs for the next edge and queue the expected post-edge state.
  task automatic step(input logic r, input logic i, input logic e,
                      input logic [0:7] exp_o, input logic exp_t_v,
                      input logic exp_e);
    exp_t x;
    @(negedge clock);
    rst_n = r;
    init  = i;
    en    = e;
    x.o  = exp_o;
    x.t  = exp_t_v;
    x.e  = exp_e;
    x.id = vec_id;
    vec_id = vec_id + 1;
    sb_q.push_back(x);
  endtask

  // Immediate (between-edge) check used for the asynchronous reset.
  task automatic check_now(input string name, input logic [0:7] exp_o);
    checks = checks + 1;
    if (out !== exp_o || tc !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL %s: out=%b tc=%b expected out=%b tc=0", name, out, tc, exp_o);
    end
  endtask

  // Monitor: after each rising edge compare the DUT against the oldest entry.
  initial begin
    exp_t x;
    forever begin
      @(posedge clock);
      #1;
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        checks = checks + 1;
`ifdef RING_ONEHOT_CHECK_EN
        if (out !== x.o || tc !== x.t || err !== x.e) begin
          failures = failures + 1;
          $display("FAIL vec%0d: out=%b tc=%b err=%b expected out=%b tc=%b err=%b",
                   x.id, out, tc, err, x.o, x.t, x.e);
        end
`else
        if (out !== x.o || tc !== x.t) begin
          failures = failures + 1;
          $display("FAIL vec%0d: out=%b tc=%b expected out=%b tc=%b",
                   x.id, out, tc, x.o, x.t);
        end
`endif
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    vec_id   = 0;
    rst_n    = 1'b1;
    init     = 1'b0;
    en       = 1'b0;

    // Asynchronous reset with no clock edge in between.
    #2 rst_n = 1'b0;
    #1 check_now("async_reset", 8'b0000_0000);

    // Held in reset; init coincident with rst_n low is ignored.
    step(1'b0, 1'b0, 1'b1, 8'b0000_0000, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 8'b0000_0000, 1'b0, 1'b0);

    // Released, no init: idle all-zeros for 10 edges.
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 1'b1, 8'b0000_0000, 1'b0, 1'b0);

    // Init then a full revolution and wrap.
    step(1'b1, 1'b1, 1'b1, walk[0], 1'b0, 1'b0);
    for (int k = 1; k < 8; k++) step(1'b1, 1'b0, 1'b1, walk[k], (k == 7), 1'b0);
    step(1'b1, 1'b0, 1'b1, walk[0], 1'b0, 1'b0);

    // Three shifts, hold with en=0 for 4 edges, then resume.
    for (int k = 1; k < 4; k++) step(1'b1, 1'b0, 1'b1, walk[k], 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b0, 8'b0001_0000, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 8'b0000_1000, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 8'b0000_0100, 1'b0, 1'b0);

    // Init priority over en, held 3 edges, then shifting resumes.
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b1, 8'b1000_0000, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 8'b0100_0000, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 8'b0010_0000, 1'b0, 1'b0);

    // Reset between edges while out=00100000.
    @(posedge clock);
    #3 rst_n = 1'b0;
    #1 check_now("midrun_reset", 8'b0000_0000);
    step(1'b0, 1'b0, 1'b1, 8'b0000_0000, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 8'b1000_0000, 1'b0, 1'b0);

    // Walk to the last stage and hold there: tc stays high.
    for (int k = 1; k < 8; k++) step(1'b1, 1'b0, 1'b1, walk[k], (k == 7), 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'b0000_0001, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'b0000_0001, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 8'b1000_0000, 1'b0, 1'b0);

`ifdef RING_ONEHOT_CHECK_EN
    // Corrupt the ring to 01100000; recovery reloads SEED and flags err.
    @(posedge clock);
    #2 force dut.out_q = 8'b0110_0000;
    #1 release dut.out_q;
    step(1'b1, 1'b0, 1'b1, 8'b1000_0000, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 8'b0100_0000, 1'b0, 1'b0);
`endif

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(posedge clock);
    #2;
    checks = checks + 1;
    if (sb_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL drain_timeout: pending=%0d expected pending=0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ring_counter.md
Name: ring_counter

Overview:
- One-hot ring counter, default 8 bits wide.
- The `init` pulse loads a single 1 into bit 0.
- On every following rising clock edge that 1 moves one position toward bit WIDTH-1, then wraps back to bit 0.
- Used as a sequencer or phase generator. Outputs come directly from registers and carry no combinational logic.

Parameters:
- WIDTH, 8, number of ring stages (minimum 2).
- SEED, {1'b1, {WIDTH-1{1'b0}}} in [0:WIDTH-1] ordering (out[0]=1), pattern loaded by init.

Ports:
- clock  input  1  rising-edge system clock.
- rst_n  input  1  asynchronous active-low reset.
- init  input  1  synchronous load of SEED, active high.
- en  input  1  shift enable, active high; tie to 1 for free-running operation.
- out  output  [0:WIDTH-1]  ring state; index 0 is the first stage.
- tc  output  1  terminal count, high while out[WIDTH-1]==1.

Behaviour:
- Reset: rst_n low forces out=all zeros and tc=0 immediately, independent of clock. The counter stays idle (all zeros) until init.
- Deassertion of rst_n takes effect at the next rising edge; no synchronizer is inside the block.
- Priority at each rising edge with rst_n high: init > en > hold.
- init=1: out <= SEED on that edge, regardless of en. Zero latency to the next edge; out shows SEED right after the sampling edge.
- init=0, en=1: rotate.
  - out[i+1] <= out[i] for i=0..WIDTH-2.
  - out[0] <= out[WIDTH-1] (wrap).
- init=0, en=0: out holds its value.
- init held high for several edges: out is reloaded with SEED on each of those edges (no shifting). Shifting resumes on the first edge after init falls.
- Period: with en=1 the pattern repeats every WIDTH edges. From SEED, out[k]=1 after k edges.
- All-zeros state rotates to all zeros. It is a stable idle state, left only by init.
- Non-one-hot states (only reachable without the optional feature via SEED override) rotate unchanged as a bit pattern.
- tc = out[WIDTH-1], registered path, no extra latency.
- Reset mid-operation: asynchronous clear to zeros. An init coincident with rst_n low is ignored.
- No X propagation: every flop has a reset value.

Optional Feature:
- Macro RING_ONEHOT_CHECK_EN.
- When defined:
  - Adds output `err` (1 bit, reset 0). `err` is a registered flag asserted one cycle after out holds a value that is not exactly one-hot while the counter is running.
  - "Running" means at least one init since reset.
  - Also on that edge, out is forced to SEED (self-recovery) instead of shifting.
  - `err` clears on the next edge where out is one-hot, or on init.
  - The all-zeros idle state before the first init is not an error.
- When undefined:
  - No `err` port, no checker logic.
  - The counter rotates whatever pattern it holds.

Test Plan:
- Reset: rst_n=0 with clock running, init=0 -> out=8'b0000_0000 and tc=0 asynchronously; after rst_n=1 with no init, out stays 0 for 10 edges.
- Init/rotate: rst_n=1, en=1, init=1 for one edge -> out=10000000 ([0:7] order); next 7 edges give 01000000, 00100000, … 00000001 with tc=1; 8th edge wraps to 10000000.
- Enable hold: after 3 shifts (out=00010000) drive en=0 for 4 edges -> out unchanged; en=1 -> 00001000 on the next edge.
- Init priority: init=1 while out=00000100 and en=1 -> out=10000000 on that edge; init held 3 edges -> remains 10000000, then shifts.
- Reset mid-run: assert rst_n=0 between edges at out=00100000 -> out=0 immediately; release and pulse init -> 10000000.
- With RING_ONEHOT_CHECK_EN: force out to 01100000 after init -> err=1 one edge later and out=10000000; the following edge gives err=0 and out=01000000.
